nr_div_seq: RTL



---
 rtl/nr_div_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/nr_div_seq.sv
// nr_div_seq: sequential non-restoring divider, one add/subtract step per clock.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned only.
module nr_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   p, p_shift, p_step, p_fix;
    logic [WIDTH-1:0] q, q_step, d, mag_a, mag_b, q_res, r_res;
    logic [CW-1:0]    count;
`ifdef DIV_SIGNED_EN
    logic             neg_q, neg_r;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Next state, the add/subtract step, the final correction and result shaping
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && divisor != '0) ? RUN : IDLE;
            RUN:     state_nx = (count == CW'(1)) ? FIX : RUN;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy    = state != IDLE;
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        p_step  = p[WIDTH] ? p_shift + {1'b0, d} : p_shift - {1'b0, d};
        q_step  = {q[WIDTH-2:0], ~p_step[WIDTH]};
        p_fix   = p[WIDTH] ? p + {1'b0, d} : p;
`ifdef DIV_SIGNED_EN
        mag_a = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b = divisor[WIDTH-1] ? -divisor : divisor;
        q_res = neg_q ? -q : q;
        r_res = neg_r ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
`else
        mag_a = dividend;
        mag_b = divisor;
        q_res = q;
        r_res = p_fix[WIDTH-1:0];
`endif
    end

    // Datapath: capture on accepted start, iterate in RUN, publish results in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        p           <= '0;
                        q           <= mag_a;
                        d           <= mag_b;
                        count       <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    p     <= p_step;
                    q     <= q_step;
                    count <= count - CW'(1);
                end
                FIX: begin
                    p         <= p_fix;
                    quotient  <= q_res;
                    remainder <= r_res;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
